rtc_bus_driver: RTL

- Synthesizable APB-style bus master for the RTC environment; sits directly upstream of the RTC slave and the bus monitor/scoreboard.
- Accepts one command at a time (read, or write to 0x00 time, 0x04 alarm, 0x08 add/sub time) on a valid/ready interface.
- Sequences each command through SETUP and ACCESS phases on the RTC bus, waits for slave ready with a timeout, and returns one response per command.

---
 rtl/rtc_bus_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: APB-style single-outstanding bus master for the RTC slave.
// Accepts one command on a valid/ready port, runs SETUP then ACCESS on the
// bus, waits for slave ready with a bounded cycle count, and returns one
// response strobe per command. A forced idle gap follows every response.
module rtc_bus_driver #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IDLE_GAP       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              rsp_err,
  output logic              sel,
  output logic              enable,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // The response cycle is already the first gap cycle, so with no gap the
  // driver returns to IDLE in the same cycle it presents the response.
  localparam state_t     POST_RSP    = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [3:0] GAP_LIM     = 4'(IDLE_GAP);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          gap_q, gap_d;
  logic                sel_q, sel_d;
  logic                enable_q, enable_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                rsp_err_q, rsp_err_d;

  // Next-state and next-output computation; the bus registers double as the
  // command latch, so nothing else needs to hold the accepted fields.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    sel_d         = sel_q;
    enable_d      = enable_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_timeout_d = 1'b0;
    rsp_err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_addr[1:0] == 2'b00) begin
            state_d  = ST_SETUP;
            sel_d    = 1'b1;
            enable_d = 1'b0;
            write_d  = cmd_write;
            addr_d   = cmd_addr;
            wdata_d  = cmd_wdata;
          end else begin
            // Misaligned: reject without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = POST_RSP;
            gap_d       = 4'd1;
          end
        end
      end
      ST_SETUP: begin
        enable_d = 1'b1;
        cnt_d    = 8'd1;
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (ready || (cnt_q == TIMEOUT_LIM)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = !ready;
          rsp_rdata_d   = (ready && !write_q) ? rdata : '0;
          sel_d         = 1'b0;
          enable_d      = 1'b0;
          write_d       = 1'b0;
          addr_d        = '0;
          wdata_d       = '0;
          state_d       = POST_RSP;
          gap_d         = 4'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_q >= GAP_LIM) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      sel_q         <= 1'b0;
      enable_q      <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      sel_q         <= sel_d;
      enable_q      <= enable_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE) && reset;
  assign sel         = sel_q;
  assign enable      = enable_q;
  assign write       = write_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_err     = rsp_err_q;

endmodule
